// File: rtl/chu_mmio_pkg.sv
// Shared types and constants for the MMIO slot fabric.
package chu_mmio_pkg;

  localparam int ADDR_W    = 21;
  localparam int ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } mmio_state_t;

endpackage

// File: rtl/chu_mmio_watchdog.sv
// Wait-state counter: cleared on the strobe cycle, counts while a slot stalls,
// flags timeout once it has waited TIMEOUT cycles.
module chu_mmio_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic timeout_o
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;

  assign timeout_o = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !timeout_o) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/chu_mmio_fabric.sv
// MMIO slot fabric: decodes FPro bus accesses onto N_SLOT slots with wait-state
// handshake, unmapped-slot detection and a timeout watchdog.
module chu_mmio_fabric
  import chu_mmio_pkg::*;
#(
  parameter int unsigned    N_SLOT    = 64,
  parameter int unsigned    SLOT_BITS = $clog2(N_SLOT),
  parameter int unsigned    REG_BITS  = 5,
  parameter int unsigned    DW        = 32,
  parameter logic [63:0]    SLOT_EN   = {64{1'b1}},
  parameter int unsigned    TIMEOUT   = 255,
  parameter logic [DW-1:0]  ERR_DATA  = 32'hFFFF_FFFF,
  parameter int unsigned    ERR_SAT_W = ERR_CNT_W
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              mmio_cs,
  input  logic                              mmio_wr,
  input  logic                              mmio_rd,
  input  logic [ADDR_W-1:0]                 mmio_addr,
  input  logic [DW-1:0]                     mmio_wr_data,
  output logic [DW-1:0]                     mmio_rd_data,
  output logic                              mmio_ready,
  output logic                              mmio_err,
  output logic [N_SLOT-1:0]                 slot_cs_array,
  output logic [N_SLOT-1:0]                 slot_mem_rd_array,
  output logic [N_SLOT-1:0]                 slot_mem_wr_array,
  output logic [N_SLOT-1:0][REG_BITS-1:0]   slot_reg_addr_array,
  output logic [N_SLOT-1:0][DW-1:0]         slot_wr_data_array,
  input  logic [N_SLOT-1:0][DW-1:0]         slot_rd_data_array,
  input  logic [N_SLOT-1:0]                 slot_ack_array,
  output logic [ERR_CNT_W-1:0]              err_count,
  output logic [SLOT_BITS-1:0]              last_err_slot
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = ERR_CNT_W'((64'd1 << ERR_SAT_W) - 64'd1);

  mmio_state_t state_q, state_d;
  logic [SLOT_BITS-1:0] slot_q, slot_d;
  logic [REG_BITS-1:0]  reg_q, reg_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic                 wr_q, wr_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [SLOT_BITS-1:0] last_err_q, last_err_d;

  logic [SLOT_BITS-1:0] req_slot;
  logic [REG_BITS-1:0]  req_reg;
  logic                 req, req_mapped;
  logic                 sel_ack;
  logic [DW-1:0]        sel_rdata;
  logic                 wd_clear, wd_en, wd_timeout;
  logic                 unused_addr_bits;

  assign req_slot   = mmio_addr[REG_BITS+SLOT_BITS-1:REG_BITS];
  assign req_reg    = mmio_addr[REG_BITS-1:0];
  assign req        = mmio_cs && (mmio_rd || mmio_wr);
  assign req_mapped = (32'(req_slot) < N_SLOT) && SLOT_EN[req_slot];
  assign unused_addr_bits = ^mmio_addr[ADDR_W-1:REG_BITS+SLOT_BITS];

  assign sel_ack   = slot_ack_array[slot_q];
  assign sel_rdata = slot_rd_data_array[slot_q];

  chu_mmio_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (wd_clear),
    .enable_i  (wd_en),
    .timeout_o (wd_timeout)
  );

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    wr_d       = wr_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    last_err_d = last_err_q;
    wd_clear   = 1'b0;
    wd_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          slot_d  = req_slot;
          reg_d   = req_reg;
          wdata_d = mmio_wr_data;
          wr_d    = mmio_wr;
          rdata_d = '0;
          err_d   = !req_mapped;
          state_d = req_mapped ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        wd_clear = 1'b1;
        if (sel_ack) begin
          rdata_d = sel_rdata;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        wd_en = 1'b1;
        if (sel_ack) begin
          rdata_d = sel_rdata;
          state_d = RESP;
        end else if (wd_timeout) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (err_q) begin
          if (err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
          last_err_d = slot_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      reg_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      last_err_q <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      last_err_q <= last_err_d;
    end
  end

  // Select stays up through ACCESS and WAIT; strobes only on the ACCESS cycle.
  always_comb begin
    for (int i = 0; i < N_SLOT; i++) begin
      slot_cs_array[i]     = ((state_q == ACCESS) || (state_q == WAIT)) && (slot_q == SLOT_BITS'(i));
      slot_mem_rd_array[i] = (state_q == ACCESS) && !wr_q && (slot_q == SLOT_BITS'(i));
      slot_mem_wr_array[i] = (state_q == ACCESS) && wr_q && (slot_q == SLOT_BITS'(i));
    end
  end

  assign slot_reg_addr_array = {N_SLOT{reg_q}};
  assign slot_wr_data_array  = {N_SLOT{wdata_q}};

  always_comb begin
    mmio_rd_data = '0;
    if (state_q == RESP) begin
      if (err_q) begin
        mmio_rd_data = ERR_DATA;
      end else if (!wr_q) begin
        mmio_rd_data = rdata_q;
      end
    end
  end

  assign mmio_ready    = (state_q == RESP);
  assign mmio_err      = (state_q == RESP) && err_q;
  assign err_count     = err_cnt_q;
  assign last_err_slot = last_err_q;

endmodule

// File: tb/tb_chu_mmio_fabric.sv
// Directed self-checking bench for chu_mmio_fabric: a 64-slot instance with
// TIMEOUT=8 and slot 9 unmapped, plus a 3-slot instance with a 4-bit saturating error count.
module tb_chu_mmio_fabric;

  logic clk;
  logic reset;

  logic               mmioCs, mmioWr, mmioRd;
  logic [20:0]        mmioAddr;
  logic [31:0]        mmioWrData;
  logic [31:0]        mmioRdData;
  logic               mmioReady, mmioErr;
  logic [63:0]        slotCs, slotRd, slotWr;
  logic [63:0][4:0]   slotRegAddr;
  logic [63:0][31:0]  slotWrData;
  logic [63:0][31:0]  slotRdData;
  logic [63:0]        slotAck;
  logic [15:0]        errCount;
  logic [5:0]         lastErrSlot;

  logic               bCs, bWr, bRd;
  logic [20:0]        bAddr;
  logic [31:0]        bWrData;
  logic [31:0]        bRdDataOut;
  logic               bReady, bErr;
  logic [2:0]         bSlotCs, bSlotRd, bSlotWr;
  logic [2:0][4:0]    bSlotRegAddr;
  logic [2:0][31:0]   bSlotWrData;
  logic [2:0][31:0]   bSlotRdData;
  logic [2:0]         bSlotAck;
  logic [15:0]        bErrCount;
  logic [1:0]         bLastErrSlot;

  int totalChecks = 0;
  int badChecks   = 0;

  chu_mmio_fabric #(
    .N_SLOT  (64),
    .SLOT_EN (64'hFFFF_FFFF_FFFF_FDFF),
    .TIMEOUT (8)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .mmio_cs             (mmioCs),
    .mmio_wr             (mmioWr),
    .mmio_rd             (mmioRd),
    .mmio_addr           (mmioAddr),
    .mmio_wr_data        (mmioWrData),
    .mmio_rd_data        (mmioRdData),
    .mmio_ready          (mmioReady),
    .mmio_err            (mmioErr),
    .slot_cs_array       (slotCs),
    .slot_mem_rd_array   (slotRd),
    .slot_mem_wr_array   (slotWr),
    .slot_reg_addr_array (slotRegAddr),
    .slot_wr_data_array  (slotWrData),
    .slot_rd_data_array  (slotRdData),
    .slot_ack_array      (slotAck),
    .err_count           (errCount),
    .last_err_slot       (lastErrSlot)
  );

  chu_mmio_fabric #(
    .N_SLOT    (3),
    .TIMEOUT   (1),
    .ERR_SAT_W (4)
  ) dutSat (
    .clk                 (clk),
    .reset               (reset),
    .mmio_cs             (bCs),
    .mmio_wr             (bWr),
    .mmio_rd             (bRd),
    .mmio_addr           (bAddr),
    .mmio_wr_data        (bWrData),
    .mmio_rd_data        (bRdDataOut),
    .mmio_ready          (bReady),
    .mmio_err            (bErr),
    .slot_cs_array       (bSlotCs),
    .slot_mem_rd_array   (bSlotRd),
    .slot_mem_wr_array   (bSlotWr),
    .slot_reg_addr_array (bSlotRegAddr),
    .slot_wr_data_array  (bSlotWrData),
    .slot_rd_data_array  (bSlotRdData),
    .slot_ack_array      (bSlotAck),
    .err_count           (bErrCount),
    .last_err_slot       (bLastErrSlot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cs, input logic wr, input logic rd,
                               input logic [20:0] addr, input logic [31:0] wdata);
    mmioCs     = cs;
    mmioWr     = wr;
    mmioRd     = rd;
    mmioAddr   = addr;
    mmioWrData = wdata;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int readyCycle;
    int readyCnt;
    int wrCnt;
    int rdCnt;
    int csCnt;
    logic [31:0] readyData;
    logic        readyErr;

    reset       = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 21'h0, 32'h0);
    slotAck     = '0;
    slotRdData  = '0;
    bCs = 1'b0; bWr = 1'b0; bRd = 1'b0; bAddr = 21'h0; bWrData = 32'h0;
    bSlotRdData = '0;
    bSlotAck    = '1;

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", mmioReady, 0);
    checkOutput("rst_cs", slotCs, 0);
    checkOutput("rst_rddata", mmioRdData, 0);
    checkOutput("rst_errcnt", errCount, 0);
    checkOutput("rst_lasterr", lastErrSlot, 0);
    checkOutput("rst_b_errcnt", bErrCount, 0);
    reset = 1'b1;
    @(negedge clk);

    // Zero-wait read, slot 3 reg 2
    slotAck[3]    = 1'b1;
    slotRdData[3] = 32'hA5A5_0001;
    applyStimulus(1'b1, 1'b0, 1'b1, 21'h062, 32'h0);
    checkOutput("t1_c0_cs", slotCs, 0);
    @(negedge clk);
    checkOutput("t1_c1_rdstb", slotRd, 64'd1 << 3);
    checkOutput("t1_c1_wrstb", slotWr, 0);
    checkOutput("t1_c1_cs", slotCs, 64'd1 << 3);
    checkOutput("t1_c1_regaddr", slotRegAddr[3], 5'd2);
    checkOutput("t1_c1_ready", mmioReady, 0);
    @(negedge clk);
    checkOutput("t1_c2_ready", mmioReady, 1);
    checkOutput("t1_c2_rddata", mmioRdData, 32'hA5A5_0001);
    checkOutput("t1_c2_err", mmioErr, 0);
    checkOutput("t1_c2_cs", slotCs, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 21'h0, 32'h0);
    @(negedge clk);

    // Write to slot 6 reg 0, ack four cycles after the strobe
    readyCycle = 0; wrCnt = 0; rdCnt = 0; csCnt = 0; readyData = '1; readyErr = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 21'h0C0, 32'h0000_1234);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      slotAck[6] = (c == 5);
      if (slotWr[6]) wrCnt++;
      if (slotRd != 0) rdCnt++;
      if (slotCs[6]) csCnt++;
      if (c == 1) checkOutput("t2_wrdata", slotWrData[6], 32'h0000_1234);
      if (mmioReady && readyCycle == 0) begin
        readyCycle = c;
        readyData  = mmioRdData;
        readyErr   = mmioErr;
        applyStimulus(1'b0, 1'b0, 1'b0, 21'h0, 32'h0);
      end
    end
    checkOutput("t2_ready_cycle", readyCycle, 6);
    checkOutput("t2_wr_strobes", wrCnt, 1);
    checkOutput("t2_rd_strobes", rdCnt, 0);
    checkOutput("t2_cs_cycles", csCnt, 5);
    checkOutput("t2_rddata", readyData, 0);
    checkOutput("t2_err", readyErr, 0);

    // Read and write both asserted: write wins
    applyStimulus(1'b1, 1'b1, 1'b1, 21'h063, 32'h0000_00AA);
    @(negedge clk);
    checkOutput("t3_wrstb", slotWr, 64'd1 << 3);
    checkOutput("t3_rdstb", slotRd, 0);
    @(negedge clk);
    checkOutput("t3_ready", mmioReady, 1);
    checkOutput("t3_rddata", mmioRdData, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 21'h0, 32'h0);
    @(negedge clk);

    // Read slot 5 acking 2 cycles late; data changes after the ack cycle
    readyCycle = 0; readyData = '0;
    applyStimulus(1'b1, 1'b0, 1'b1, 21'h0A1, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      slotAck[5]    = (c == 3);
      slotRdData[5] = (c <= 3) ? 32'hC0DE_0005 : 32'hDEAD_BEEF;
      if (mmioReady && readyCycle == 0) begin
        readyCycle = c;
        readyData  = mmioRdData;
        applyStimulus(1'b0, 1'b0, 1'b0, 21'h0, 32'h0);
      end
    end
    checkOutput("t4_ready_cycle", readyCycle, 4);
    checkOutput("t4_captured", readyData, 32'hC0DE_0005);

    // Unmapped slot 9
    slotAck[9] = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 21'h120, 32'h0);
    @(negedge clk);
    checkOutput("t5_ready", mmioReady, 1);
    checkOutput("t5_err", mmioErr, 1);
    checkOutput("t5_rddata", mmioRdData, 32'hFFFF_FFFF);
    checkOutput("t5_cs", slotCs, 0);
    checkOutput("t5_rdstb", slotRd, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 21'h0, 32'h0);
    @(negedge clk);
    checkOutput("t5_errcnt", errCount, 1);
    checkOutput("t5_lasterr", lastErrSlot, 9);

    // Timeout on slot 12, late ack on cycle 12
    readyCycle = 0; readyCnt = 0; readyData = '0; readyErr = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 21'h180, 32'h0);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      slotAck[12] = (c == 12);
      if (mmioReady) begin
        readyCnt++;
        if (readyCycle == 0) begin
          readyCycle = c;
          readyData  = mmioRdData;
          readyErr   = mmioErr;
          applyStimulus(1'b0, 1'b0, 1'b0, 21'h0, 32'h0);
        end
      end
    end
    checkOutput("t6_ready_cycle", readyCycle, 10);
    checkOutput("t6_ready_count", readyCnt, 1);
    checkOutput("t6_err", readyErr, 1);
    checkOutput("t6_rddata", readyData, 32'hFFFF_FFFF);
    checkOutput("t6_errcnt", errCount, 2);
    checkOutput("t6_lasterr", lastErrSlot, 12);

    // Reset during WAIT on slot 20
    applyStimulus(1'b1, 1'b0, 1'b1, 21'h280, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t7_wait_cs", slotCs, 64'd1 << 20);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t7_rst_cs", slotCs, 0);
    checkOutput("t7_rst_ready", mmioReady, 0);
    checkOutput("t7_rst_errcnt", errCount, 0);
    checkOutput("t7_rst_lasterr", lastErrSlot, 0);
    checkOutput("t7_rst_regaddr", slotRegAddr[20], 0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 21'h0, 32'h0);
    @(negedge clk);
    checkOutput("t7_post_ready", mmioReady, 0);
    slotAck[20]    = 1'b1;
    slotRdData[20] = 32'h0055_AA20;
    applyStimulus(1'b1, 1'b0, 1'b1, 21'h284, 32'h0);
    @(negedge clk);
    checkOutput("t7_again_rdstb", slotRd, 64'd1 << 20);
    checkOutput("t7_again_regaddr", slotRegAddr[20], 5'd4);
    @(negedge clk);
    checkOutput("t7_again_ready", mmioReady, 1);
    checkOutput("t7_again_rddata", mmioRdData, 32'h0055_AA20);
    checkOutput("t7_again_err", mmioErr, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 21'h0, 32'h0);
    @(negedge clk);

    // Saturation on the small instance: slot 3 lies beyond N_SLOT=3
    readyCnt = 0; csCnt = 0;
    bAddr = 21'h060; bRd = 1'b1; bCs = 1'b1;
    for (int c = 0; c < 100 && readyCnt < 15; c++) begin
      @(negedge clk);
      if (bSlotCs != 0) csCnt++;
      if (bReady) begin
        readyCnt++;
        if (readyCnt == 15) bCs = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("t8_ready_count", readyCnt, 15);
    checkOutput("t8_errcnt_max", bErrCount, 15);
    checkOutput("t8_lasterr", bLastErrSlot, 3);
    bCs = 1'b1;
    @(negedge clk);
    checkOutput("t8_extra_ready", bReady, 1);
    checkOutput("t8_extra_err", bErr, 1);
    checkOutput("t8_extra_rddata", bRdDataOut, 32'hFFFF_FFFF);
    bCs = 1'b0;
    @(negedge clk);
    checkOutput("t8_errcnt_sat", bErrCount, 15);
    checkOutput("t8_cs_never", csCnt, 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
